clk_div_multi: RTL and testbench



---
 rtl/clk_div_pkg.sv | 14 +
 rtl/clk_div_chan.sv | 85 ++++++++
 rtl/clk_div_multi.sv | 84 ++++++++
 tb/tb_clk_div_multi.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants, channel-select width helper and divide-value type for clk_div_multi.
package clk_div_pkg;

  localparam int unsigned DEF_CNT_W = 26;
  localparam int unsigned DEF_DIV   = 1;

  typedef logic [DEF_CNT_W-1:0] div_t;

  // Channel-select width: clog2 of the channel count, never narrower than one bit.
  function automatic int unsigned ch_w_f(input int unsigned n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divide values with a pending flag, clk_out and tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] active_q, active_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  always_comb begin
    // NOTE: every target gets a default first so no path leaves it unassigned (no latch).
    cnt_d     = cnt_q;
    active_d  = active_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (restart || !en) begin
      // Idle or phase realignment: park the channel and take any queued divide value now.
      cnt_d     = '0;
      clk_out_d = 1'b0;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else if (cnt_q == active_q) begin
      cnt_d     = '0;
      clk_out_d = ~clk_out_q;
      tick_d    = 1'b1;
      if (pending_q) begin
        active_d  = shadow_q;
        pending_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A load is only accepted while nothing is pending, so it never collides with an apply.
    if (load) begin
      shadow_d  = load_div;
      pending_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      active_q  <= RST_DIV;
      shadow_q  <= RST_DIV;
      pending_q <= 1'b0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      active_q  <= active_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign pending = pending_q;

endmodule

// File: rtl/clk_div_multi.sv
// NUM_CH programmable clock dividers with a valid/ready config port.
// Optional macro CLKDIV_SYNC_EN adds sync_restart to phase-align all channels.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned CNT_W       = DEF_CNT_W,
  parameter int unsigned DEFAULT_DIV = DEF_DIV
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_CH-1:0]           ch_en,
`ifdef CLKDIV_SYNC_EN
  input  logic                        sync_restart,
`endif
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [ch_w_f(NUM_CH)-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]            cfg_div,
  output logic                        cfg_err,
  output logic [NUM_CH-1:0]           clk_out,
  output logic [NUM_CH-1:0]           tick
);

  localparam int unsigned CH_W = ch_w_f(NUM_CH);

  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] load;
  logic              in_range;
  logic              sel_pending;
  logic              accept;
  logic              restart;
  logic              cfg_err_q, cfg_err_d;

`ifdef CLKDIV_SYNC_EN
  assign restart = sync_restart;
`else
  assign restart = 1'b0;
`endif

  // Decode cfg_ch by comparison so out-of-range codes never index past the channel array.
  always_comb begin
    in_range    = 1'b0;
    sel_pending = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        in_range    = 1'b1;
        sel_pending = pending[i];
      end
    end
    cfg_ready = in_range ? ~sel_pending : 1'b1;
    accept    = cfg_valid & cfg_ready;
    load      = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      load[i] = accept & (cfg_ch == CH_W'(i));
    end
    cfg_err_d = accept & ~in_range;
  end

  always_ff @(posedge clk) begin
    if (rst) cfg_err_q <= 1'b0;
    else     cfg_err_q <= cfg_err_d;
  end

  assign cfg_err = cfg_err_q;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    clk_div_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (ch_en[g]),
      .restart  (restart),
      .load     (load[g]),
      .load_div (cfg_div),
      .clk_out  (clk_out[g]),
      .tick     (tick[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Scoreboard bench for clk_div_multi: a wrap-time reference model feeds an expectation queue
// that a negedge monitor drains; exercises CLKDIV_SYNC_EN when that macro is defined.
module tb_clk_div_multi;
  import clk_div_pkg::*;

  localparam int unsigned NUM_CH      = 5;
  localparam int unsigned CNT_W       = 8;
  localparam int unsigned DEFAULT_DIV = DEF_DIV;
  localparam int unsigned CH_W        = ch_w_f(NUM_CH);

  logic              clk = 1'b0;
  logic              rst;
  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_err;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick;
`ifdef CLKDIV_SYNC_EN
  logic              sync_restart;
`endif

  initial forever #5 clk = ~clk;

  clk_div_multi #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ch_en        (ch_en),
`ifdef CLKDIV_SYNC_EN
    .sync_restart (sync_restart),
`endif
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_ch       (cfg_ch),
    .cfg_div      (cfg_div),
    .cfg_err      (cfg_err),
    .clk_out      (clk_out),
    .tick         (tick)
  );

  typedef struct packed {
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic              err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: each channel remembers the absolute edge number of its next wrap.
  int                m_t = 0;
  bit                m_live = 1'b0;
  int                m_div   [NUM_CH];
  int                m_shadow[NUM_CH];
  int                m_next  [NUM_CH];
  bit                m_pend  [NUM_CH];
  logic [NUM_CH-1:0] m_clk;
  logic [NUM_CH-1:0] m_tick;
  logic              m_err;

  function automatic bit m_ready(input int ch);
    if (ch >= int'(NUM_CH)) return 1'b1;
    return !m_pend[ch];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_step();
    bit acc;
    bit rs;
    int ch;
    m_t++;
    rs = 1'b0;
`ifdef CLKDIV_SYNC_EN
    rs = sync_restart;
`endif
    if (rst) begin
      m_live = 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
        m_div[i]    = DEFAULT_DIV;
        m_shadow[i] = DEFAULT_DIV;
        m_pend[i]   = 1'b0;
        m_next[i]   = m_t + DEFAULT_DIV + 1;
      end
      m_clk  = '0;
      m_tick = '0;
      m_err  = 1'b0;
    end else if (m_live) begin
      ch  = int'(cfg_ch);
      acc = cfg_valid && m_ready(ch);
      for (int i = 0; i < NUM_CH; i++) begin
        if (rs || !ch_en[i]) begin
          if (m_pend[i]) begin
            m_div[i]  = m_shadow[i];
            m_pend[i] = 1'b0;
          end
          m_clk[i]  = 1'b0;
          m_tick[i] = 1'b0;
          m_next[i] = m_t + m_div[i] + 1;
        end else if (m_t == m_next[i]) begin
          m_clk[i]  = ~m_clk[i];
          m_tick[i] = 1'b1;
          if (m_pend[i]) begin
            m_div[i]  = m_shadow[i];
            m_pend[i] = 1'b0;
          end
          m_next[i] = m_t + m_div[i] + 1;
        end else begin
          m_tick[i] = 1'b0;
        end
      end
      if (acc && ch < int'(NUM_CH)) begin
        m_shadow[ch] = int'(cfg_div);
        m_pend[ch]   = 1'b1;
      end
      m_err = acc && (ch >= int'(NUM_CH));
    end
    if (m_live) exp_q.push_back('{clk_out: m_clk, tick: m_tick, err: m_err});
  endtask

  task automatic monitor_step();
    exp_t e;
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check("clk_out",   32'(clk_out),   32'(e.clk_out));
    check("tick",      32'(tick),      32'(e.tick));
    check("cfg_err",   32'(cfg_err),   32'(e.err));
    check("cfg_ready", 32'(cfg_ready), 32'(m_ready(int'(cfg_ch))));
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    monitor_step();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Holds the request until the DUT accepts it, with a bounded wait.
  task automatic cfg_write(input int ch, input int dv);
    bit acc = 1'b0;
    int n   = 0;
    cfg_valid = 1'b1;
    cfg_ch    = CH_W'(ch);
    cfg_div   = CNT_W'(dv);
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = cfg_ready;
      n++;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL cfg_timeout ch=%0d: got no accept, expected accept within 200 cycles", ch);
    end
  endtask

  initial begin
    rst       = 1'b1;
    ch_en     = '0;
    cfg_valid = 1'b0;
    cfg_ch    = '0;
    cfg_div   = '0;
`ifdef CLKDIV_SYNC_EN
    sync_restart = 1'b0;
`endif
    step(2);
    rst = 1'b0;

    // Channel 0 alone at the reset divide value.
    ch_en = 5'b00001;
    step(12);

    // Reprogram ch1 while running, then a second write that must wait for the wrap.
    ch_en = 5'b00011;
    step(5);
    cfg_write(1, 4);
    cfg_write(1, 2);
    step(25);

    // Out-of-range channel codes.
    cfg_write(5, 9);
    step(2);
    cfg_write(7, 3);
    step(3);

    // div=0 on ch2, then disable mid-run and re-enable.
    ch_en[2] = 1'b1;
    cfg_write(2, 0);
    step(10);
    ch_en[2] = 1'b0;
    step(3);
    ch_en[2] = 1'b1;
    step(6);

    // Reset while ch3 has a pending load.
    ch_en[3] = 1'b1;
    cfg_write(3, 12);
    step(20);
    cfg_write(3, 5);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    ch_en = 5'b01111;
    step(8);

`ifdef CLKDIV_SYNC_EN
    // Phase-align ch0 (div 1) and ch1 (div 2), with a config accept on the restart edge.
    ch_en = 5'b00011;
    cfg_write(0, 1);
    cfg_write(1, 2);
    step(7);
    sync_restart = 1'b1;
    cfg_valid    = 1'b1;
    cfg_ch       = CH_W'(3);
    cfg_div      = CNT_W'(4);
    step(1);
    sync_restart = 1'b0;
    cfg_valid    = 1'b0;
    step(10);
`endif

    // Randomised traffic.
    for (int it = 0; it < 1500; it++) begin
      int r;
      int k;
      r = int'($urandom_range(0, 99));
      if (r < 2) begin
        rst = 1'b1;
        step(1);
        rst = 1'b0;
      end else if (r < 5) begin
`ifdef CLKDIV_SYNC_EN
        sync_restart = 1'b1;
        step(1);
        sync_restart = 1'b0;
`else
        step(1);
`endif
      end else if (r < 20) begin
        k = int'($urandom_range(0, NUM_CH - 1));
        ch_en[k] = ~ch_en[k];
        step(1);
      end else if (r < 40) begin
        cfg_write(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      end else begin
        step(1);
      end
    end

    step(3);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
